// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N:1 valid/ready stream multiplexer with a registered output.
// Each cycle one offering channel is granted, by round-robin (MODE 0) or by
// fixed lowest-index priority (MODE 1). Its beat lands in a single output
// register, which also reports the source channel index on out_sel.
module mux_rr_stream #(
    parameter int WIDTH = 2,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Output register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    out_data_reg;
    logic [SELW-1:0]     out_sel_reg;
    logic [SELW-1:0]     ptr_reg, ptr_next;

    // Per-channel views of the packed input data bus
    logic [WIDTH-1:0]    chan_data [N];
    // Channel examined at search position k (rotated by ptr in round-robin mode)
    logic [SELW-1:0]     cand_idx [N];

    logic [SELW-1:0]     grant_idx;
    logic                grant_found;
    logic [N-1:0]        grant_onehot;
    logic                any_valid;
    logic                load;
    logic                transfer;

    genvar gi;

    // Slice the flat input bus into per-channel words
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Build the search order. Round-robin starts at ptr and wraps modulo N;
    // fixed priority always starts at channel 0. The sum is one bit wider
    // than the index so ptr+k never overflows before the wrap compare.
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            if (MODE == 0) begin : g_rr
                logic [SELW:0] sum;
                assign sum = {1'b0, ptr_reg} + (SELW+1)'(gi);
                assign cand_idx[gi] = (sum >= (SELW+1)'(N))
                                    ? SELW'(sum - (SELW+1)'(N))
                                    : SELW'(sum);
            end else begin : g_fixed
                assign cand_idx[gi] = SELW'(gi);
            end
        end
    endgenerate

    // First offering channel in search order wins the grant
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!grant_found && in_valid[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    // One-hot decode of the granted index
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign grant_onehot[gi] = (grant_idx == SELW'(gi));
        end
    endgenerate

    // The output register can accept a beat when it is empty or draining;
    // this is the only path from out_ready to in_ready.
    assign any_valid = |in_valid;
    assign load      = (state_reg == EMPTY) || out_ready;
    assign transfer  = load && any_valid && !rst;
    assign in_ready  = transfer ? grant_onehot : '0;

    // Round-robin pointer moves just past the channel that was served
    generate
        if (MODE == 0) begin : g_ptr_rr
            always_comb begin
                ptr_next = ptr_reg;
                if (transfer) begin
                    ptr_next = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
                end
            end
        end else begin : g_ptr_fixed
            always_comb begin
                ptr_next = '0;
            end
        end
    endgenerate

    // Occupancy next-state: a new beat keeps us FULL, a drain with nothing
    // arriving empties the register, stalled FULL holds.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: begin
                if (transfer) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_next = transfer ? FULL : EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // State, output register and pointer; data/sel only change on a transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= EMPTY;
            out_data_reg <= '0;
            out_sel_reg  <= '0;
            ptr_reg      <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            if (transfer) begin
                out_data_reg <= chan_data[grant_idx];
                out_sel_reg  <= grant_idx;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;
    assign out_valid = (state_reg == FULL);

endmodule
